// File: rtl/picorv32_rr_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port among cores.
// Define PICO_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module picorv32_rr_arbiter #(
    parameter int CORES_COUNT = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [CORES_COUNT-1:0]      mem_valid_i,
    input  logic [CORES_COUNT-1:0]      mem_instr_i,
    input  logic [CORES_COUNT-1:0][31:0] mem_addr_i,
    input  logic [CORES_COUNT-1:0][31:0] mem_wdata_i,
    input  logic [CORES_COUNT-1:0][3:0]  mem_wstrb_i,
    output logic [CORES_COUNT-1:0]      mem_ready_o,
    output logic [CORES_COUNT-1:0][31:0] mem_rdata_o,
    output logic                        mem_valid_o,
    output logic                        mem_instr_o,
    output logic [31:0]                 mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    output logic [3:0]                  mem_wstrb_o,
    input  logic                        mem_ready_i,
    input  logic [31:0]                 mem_rdata_i,
    output logic [CORES_COUNT-1:0]      grant_o
);

    localparam int PW = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          g_q, g_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CORES_COUNT-1:0] grant_q, grant_d;
    logic                   found;
    logic [PW-1:0]          win;
    logic [PW-1:0]          idx;

    // Scan starts just above the last owner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < CORES_COUNT; k++) begin
`ifdef PICO_ARB_FIXED_PRIO_EN
            idx = PW'(k);
`else
            idx = PW'((int'(ptr_q) + 1 + k) % CORES_COUNT);
`endif
            if (!found && mem_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = BUSY;
                    g_d          = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                    ptr_d   = g_q;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_valid_o = 1'b0;
        mem_instr_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        mem_ready_o = '0;
        if (state_q == BUSY) begin
            mem_valid_o      = mem_valid_i[g_q];
            mem_instr_o      = mem_instr_i[g_q];
            mem_addr_o       = mem_addr_i[g_q];
            mem_wdata_o      = mem_wdata_i[g_q];
            mem_wstrb_o      = mem_wstrb_i[g_q];
            mem_ready_o[g_q] = mem_ready_i;
        end
    end

    assign mem_rdata_o = {CORES_COUNT{mem_rdata_i}};
    assign grant_o     = grant_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= PW'(CORES_COUNT - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_picorv32_rr_arbiter.sv
// Directed vector bench for picorv32_rr_arbiter with three cores.
// Rows are driven at negedge and checked 1 ns later, before the next posedge.
module tb_picorv32_rr_arbiter;

    localparam int N = 3;
`ifdef PICO_ARB_FIXED_PRIO_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               resetn;
    logic [N-1:0]       valid_i;
    logic [N-1:0]       instr_i;
    logic [N-1:0][31:0] addr_i;
    logic [N-1:0][31:0] wdata_i;
    logic [N-1:0][3:0]  wstrb_i;
    logic [N-1:0]       ready_o;
    logic [N-1:0][31:0] rdata_o;
    logic               valid_o;
    logic               instr_o;
    logic [31:0]        addr_o;
    logic [31:0]        wdata_o;
    logic [3:0]         wstrb_o;
    logic               ready_i;
    logic [31:0]        rdata_i;
    logic [N-1:0]       grant_o;

    picorv32_rr_arbiter #(.CORES_COUNT(N)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_valid_i (valid_i),
        .mem_instr_i (instr_i),
        .mem_addr_i  (addr_i),
        .mem_wdata_i (wdata_i),
        .mem_wstrb_i (wstrb_i),
        .mem_ready_o (ready_o),
        .mem_rdata_o (rdata_o),
        .mem_valid_o (valid_o),
        .mem_instr_o (instr_o),
        .mem_addr_o  (addr_o),
        .mem_wdata_o (wdata_o),
        .mem_wstrb_o (wstrb_o),
        .mem_ready_i (ready_i),
        .mem_rdata_i (rdata_i),
        .grant_o     (grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic [2:0]  v;
        logic        rdy;
        logic [31:0] rd;
        int          own;
    } vec_t;

    vec_t tbl[$];
    int   vecs = 0;
    int   errs = 0;

    logic [31:0] c_addr [N] = '{32'h0000_0040, 32'h0000_0100, 32'h0000_0008};
    logic [31:0] c_wdat [N] = '{32'h0, 32'h0, 32'hCAFE_F00D};
    logic [3:0]  c_wstb [N] = '{4'h0, 4'h0, 4'b0011};
    logic        c_inst [N] = '{1'b1, 1'b0, 1'b0};

    task automatic add(input logic r, input logic [2:0] v, input logic rdy,
                       input logic [31:0] rd, input int own);
        vec_t e;
        e.rstn = r; e.v = v; e.rdy = rdy; e.rd = rd; e.own = own;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [127:0] act, input logic [127:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, id, act, exp);
        end
    endtask

    task automatic apply(input vec_t e, input int id);
        logic        evo;
        logic        ein;
        logic [31:0] eao;
        logic [31:0] ewd;
        logic [3:0]  ews;
        logic [2:0]  ero;
        logic [2:0]  ego;
        @(negedge clk);
        resetn  = e.rstn;
        valid_i = e.v;
        ready_i = e.rdy;
        rdata_i = e.rd;
        #1;
        evo = 1'b0; ein = 1'b0; eao = '0; ewd = '0; ews = '0;
        ero = '0; ego = '0;
        if (e.own >= 0) begin
            evo = 1'b1;
            ein = c_inst[e.own];
            eao = c_addr[e.own];
            ewd = c_wdat[e.own];
            ews = c_wstb[e.own];
            ego = 3'(1 << e.own);
            ero = e.rdy ? ego : 3'b000;
        end
        chk("valid_o", id, 128'(valid_o), 128'(evo));
        chk("instr_o", id, 128'(instr_o), 128'(ein));
        chk("addr_o",  id, 128'(addr_o),  128'(eao));
        chk("wdata_o", id, 128'(wdata_o), 128'(ewd));
        chk("wstrb_o", id, 128'(wstrb_o), 128'(ews));
        chk("ready_o", id, 128'(ready_o), 128'(ero));
        chk("grant_o", id, 128'(grant_o), 128'(ego));
        chk("rdata_o", id, 128'(rdata_o), 128'({N{e.rd}}));
        vecs++;
    endtask

    initial begin
        int exp_g;
        bit got;
        for (int i = 0; i < N; i++) begin
            addr_i[i]  = c_addr[i];
            wdata_i[i] = c_wdat[i];
            wstrb_i[i] = c_wstb[i];
            instr_i[i] = c_inst[i];
        end
        resetn  = 1'b0;
        valid_i = 3'b111;
        ready_i = 1'b0;
        rdata_i = 32'h0;

        // reset held with every core requesting
        add(0, 3'b111, 0, 32'h0, -1);
        add(0, 3'b111, 1, 32'h5, -1);
        add(1, 3'b111, 0, 32'h0, -1);
        // fairness: all request continuously
        add(1, 3'b111, 0, 32'h0, 0);
        add(1, 3'b111, 1, 32'hAAAA_0000, 0);
        add(1, 3'b111, 0, 32'h0, -1);
        add(1, 3'b111, 1, 32'hAAAA_0001, FIX ? 0 : 1);
        add(1, 3'b111, 0, 32'h0, -1);
        add(1, 3'b111, 1, 32'hAAAA_0002, FIX ? 0 : 2);
        add(1, 3'b111, 0, 32'h0, -1);
        add(1, 3'b111, 1, 32'hAAAA_0003, 0);
        add(1, 3'b111, 0, 32'h0, -1);
        add(1, 3'b111, 1, 32'hAAAA_0004, FIX ? 0 : 1);
        add(1, 3'b111, 0, 32'h0, -1);
        add(1, 3'b111, 1, 32'hAAAA_0005, FIX ? 0 : 2);
        add(1, 3'b000, 0, 32'h0, -1);
        // single read by core1, ready three cycles after grant
        add(1, 3'b010, 0, 32'h0, -1);
        add(1, 3'b010, 0, 32'h0, 1);
        add(1, 3'b010, 0, 32'h0, 1);
        add(1, 3'b010, 0, 32'h0, 1);
        add(1, 3'b010, 1, 32'h1234_5678, 1);
        add(1, 3'b000, 0, 32'h0, -1);
        // write by core2
        add(1, 3'b100, 0, 32'h0, -1);
        add(1, 3'b100, 0, 32'h0, 2);
        add(1, 3'b100, 1, 32'h0, 2);
        add(1, 3'b000, 0, 32'h0, -1);
        // reset while core0 waits
        add(1, 3'b001, 0, 32'h0, -1);
        add(1, 3'b001, 0, 32'h0, 0);
        add(0, 3'b001, 0, 32'h0, 0);
        add(1, 3'b000, 1, 32'h0, -1);
        // pointer was reset, so core0 beats core1
        add(1, 3'b011, 0, 32'h0, -1);
        add(1, 3'b011, 1, 32'h9, 0);
        add(1, 3'b000, 0, 32'h0, -1);

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // cores 0 and 2 request continuously; last owner was core0
        valid_i = 3'b101;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                @(negedge clk);
                ready_i = 1'b0;
                #1;
                if (grant_o != '0) got = 1'b1;
            end
            exp_g = FIX ? 1 : ((t % 2 == 0) ? 4 : 1);
            vecs++;
            if (!got) begin
                errs++;
                $display("FAIL grant_timeout txn %0d: got none want %0h",
                         t, exp_g);
            end else begin
                chk("seq_grant", t, 128'(grant_o), 128'(exp_g));
                ready_i = 1'b1;
                #1;
                chk("seq_ready", t, 128'(ready_o), 128'(exp_g));
            end
        end
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
